bias_add_sequencer: RTL and testbench
=====================================

BIAS_ADD_SEQUENCER -- requirements
Module: bias_add_sequencer

Interface
REQ-001 SHALL have parameter N_adder_tree, default 16, number of parallel lanes.
REQ-002 SHALL have parameter DW, default 18, lane width in bits (signed two's complement).
REQ-003 SHALL have parameter NUM_GROUPS, default 64, number of bias groups per tile.
REQ-004 SHALL have parameter RELU_EN, default 1; 1 clamps negative results to zero.
REQ-005 SHALL have the following ports:
  clk  input  1  clock, rising edge.
  rst  input  1  asynchronous, active-high reset.
  start  input  1  begin tile; sampled only in IDLE.
  acc_in  input  N_adder_tree*DW  adder-tree results; lane i at [DW*(i+1)-1:DW*i].
  acc_valid  input  1  acc_in valid.
  acc_ready  output  1  block accepts acc_in this cycle.
  bias_sel  output  clog2(NUM_GROUPS)  selects the BIAS bank group feeding bias_in.
  bias_in  input  N_adder_tree*DW  bias vector for bias_sel; same lane packing as acc_in.
  out_data  output  N_adder_tree*DW  biased, saturated, optionally rectified result.
  out_valid  output  1  out_data valid.
  out_ready  input  1  downstream accepts out_data.
  busy  output  1  high in RUN and DRAIN.
  done  output  1  one-cycle pulse at tile completion.

Function
REQ-006 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-007 IDLE: acc_ready=0; start=1 -> RUN, group counter cleared to 0.
REQ-008 RUN: acc_ready = !out_valid || out_ready (single-entry output register).
REQ-009 Transfer occurs on acc_valid && acc_ready; transfers SHALL be the only events that advance the group counter.
REQ-010 On transfer, each lane SHALL compute the DW+1-bit sum acc_in lane + bias_in lane, saturate to [-2^(DW-1), 2^(DW-1)-1], apply ReLU if RELU_EN=1, and register the result into out_data with out_valid=1 on the next edge (latency 1 cycle).
REQ-011 bias_sel SHALL equal the group counter combinationally from the register; bias_in SHALL be treated as combinational from bias_sel and consumed in the same cycle as the transfer.
REQ-012 out_valid SHALL clear on out_valid && out_ready with no simultaneous transfer; simultaneous consume and transfer SHALL keep out_valid=1 with new data (no bubble).
REQ-013 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-014 On transfer with group = NUM_GROUPS-1: counter wraps to 0, FSM -> DRAIN.
REQ-015 DRAIN: acc_ready=0; when out_valid=0, or out_valid && out_ready, FSM -> IDLE and done=1 for exactly that cycle.
REQ-016 start asserted in RUN or DRAIN SHALL be ignored; start in the IDLE cycle following done SHALL start a new tile.
REQ-017 acc_valid in IDLE or DRAIN SHALL be ignored; no lane data is lost or duplicated.
REQ-018 busy SHALL be 1 exactly when state is RUN or DRAIN.

Reset
REQ-019 rst=1 SHALL asynchronously force state IDLE, group counter 0, out_data 0, out_valid 0, done 0, busy 0, acc_ready 0.
REQ-020 rst asserted mid-tile SHALL abandon the tile; no done pulse; the next start restarts at group 0.

Verification
REQ-021 Basic: start, 64 back-to-back transfers with out_ready=1, lane0 acc=100, bias group g lane0=g -> out lane0 = 100+g, latency 1, bias_sel 0..63, done once, 1 cycle after the last output is consumed.
REQ-022 Saturation/ReLU: acc lane=131071, bias=+10 -> 131071; acc=-131072, bias=-5 -> 0 with RELU_EN=1, -131072 with RELU_EN=0.
REQ-023 Backpressure: out_ready=0 for 5 cycles after the first output -> acc_ready=0, out_data stable, bias_sel held; release -> stream resumes with no loss or duplication.
REQ-024 Handshake: random acc_valid/out_ready over 3 tiles -> output sequence matches the reference model exactly; 64 outputs and one done per tile.
REQ-025 Reset mid-tile: rst at group 30 -> all outputs 0 immediately; no done; a new start yields bias_sel=0 on the first transfer.
REQ-026 start during RUN/DRAIN and acc_valid in IDLE -> no state change, no output.

Source files
------------

// File: rtl/bias_add_sequencer.sv
// bias_add_sequencer
// Adds a per-group bias vector to each adder-tree result, saturates every lane
// to DW bits and optionally rectifies it. One tile covers NUM_GROUPS results;
// the group counter addresses the bias bank and advances once per accepted
// result.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               begin a tile (honoured only while idle)
//   acc_in/acc_valid    adder-tree lanes in, acc_ready = accepted this cycle
//   bias_sel/bias_in    bias bank group select, bias lanes for that group
//   out_data/out_valid  registered result, out_ready = downstream consumes
//   busy                tile in progress (RUN or DRAIN)
//   done                one-cycle pulse once the last result is consumed
module bias_add_sequencer #(
  parameter int unsigned N_adder_tree = 16,
  parameter int unsigned DW           = 18,
  parameter int unsigned NUM_GROUPS   = 64,
  parameter int unsigned RELU_EN      = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [N_adder_tree*DW-1:0]            acc_in,
  input  logic                                  acc_valid,
  output logic                                  acc_ready,
  output logic [$clog2(NUM_GROUPS)-1:0]         bias_sel,
  input  logic [N_adder_tree*DW-1:0]            bias_in,
  output logic [N_adder_tree*DW-1:0]            out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  busy,
  output logic                                  done
);

  localparam int unsigned GW = $clog2(NUM_GROUPS);
  localparam int unsigned VW = N_adder_tree * DW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   grp, grp_nxt;
  logic            done_nxt;
  logic            xfer;
  logic            last_grp;
  logic [VW-1:0]   result_c;

  // Single-entry output register: accept when empty or being emptied.
  assign acc_ready = (state == RUN) && (!out_valid || out_ready);
  assign xfer      = acc_valid && acc_ready;
  assign last_grp  = (grp == GW'(NUM_GROUPS - 1));
  assign bias_sel  = grp;

  // Per-lane bias add with one guard bit, saturation and optional ReLU.
  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    logic [DW:0]   sum;
    logic [DW-1:0] sat;
    logic [DW-1:0] res;

    assign sum = {acc_in[DW*i+DW-1], acc_in[DW*i +: DW]}
               + {bias_in[DW*i+DW-1], bias_in[DW*i +: DW]};

    always_comb begin
      sat = sum[DW-1:0];
      // Guard bit disagreeing with the sign bit means the sum left the DW range.
      if (sum[DW] != sum[DW-1]) begin
        sat = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
      res = sat;
      if ((RELU_EN != 0) && sat[DW-1]) begin
        res = '0;
      end
    end

    assign result_c[DW*i +: DW] = res;
  end

  // Next-state logic; the group counter moves only on a transfer.
  always_comb begin
    state_nxt = state;
    grp_nxt   = grp;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          grp_nxt   = '0;
        end
      end
      RUN: begin
        if (xfer) begin
          if (last_grp) begin
            grp_nxt   = '0;
            state_nxt = DRAIN;
          end else begin
            grp_nxt = grp + GW'(1);
          end
        end
      end
      DRAIN: begin
        // Finish once the final result has left (or is leaving) the register.
        if (!out_valid || out_ready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grp   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      grp   <= grp_nxt;
      done  <= done_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Output register; a transfer overrides a simultaneous consume (no bubble).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_data  <= result_c;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bias_add_sequencer.sv
module tb_bias_add_sequencer;

  localparam int unsigned N  = 16;
  localparam int unsigned DW = 18;
  localparam int unsigned G  = 64;
  localparam int unsigned GW = $clog2(G);
  localparam int unsigned VW = N * DW;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [VW-1:0] acc_in;
  logic          acc_valid;
  logic          out_ready;
  logic [VW-1:0] bias_mem [G];

  logic          acc_ready, acc_ready_n;
  logic [GW-1:0] bias_sel, bias_sel_n;
  logic [VW-1:0] bias_in, bias_in_n;
  logic [VW-1:0] out_data, out_data_n;
  logic          out_valid, out_valid_n;
  logic          busy, busy_n, done, done_n;

  assign bias_in   = bias_mem[bias_sel];
  assign bias_in_n = bias_mem[bias_sel_n];

  always #5 clk = ~clk;

  bias_add_sequencer #(.N_adder_tree(N), .DW(DW), .NUM_GROUPS(G), .RELU_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .acc_in(acc_in), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .bias_sel(bias_sel), .bias_in(bias_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done));

  bias_add_sequencer #(.N_adder_tree(N), .DW(DW), .NUM_GROUPS(G), .RELU_EN(0)) dut_n (
    .clk(clk), .rst(rst), .start(start), .acc_in(acc_in), .acc_valid(acc_valid),
    .acc_ready(acc_ready_n), .bias_sel(bias_sel_n), .bias_in(bias_in_n),
    .out_data(out_data_n), .out_valid(out_valid_n), .out_ready(out_ready),
    .busy(busy_n), .done(done_n));

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lane_val(input logic [VW-1:0] v, input int i);
    logic signed [DW-1:0] x;
    x = v[i*DW +: DW];
    return int'(x);
  endfunction

  // Reference: plain integer add, clamp to the DW range, optional rectify.
  function automatic logic [VW-1:0] model_out(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                              input bit relu);
    logic [VW-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < N; i++) begin
      s = lane_val(a, i) + lane_val(b, i);
      if (s > MAXV) s = MAXV;
      if (s < MINV) s = MINV;
      if (relu && s < 0) s = 0;
      r[i*DW +: DW] = DW'(s);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_lane();
    case ($urandom_range(0, 7))
      0:       return DW'(MAXV);
      1:       return DW'(MINV);
      2:       return DW'(int'($urandom_range(0, 40)) - 20);
      default: return DW'($urandom);
    endcase
  endfunction

  // Behavioural model state, owned by the compare process.
  int            m_st = 0;          // 0 idle, 1 run, 2 drain
  int            m_g = 0;
  bit            m_xfer = 1'b0;
  bit            e_ov = 1'b0, e_done = 1'b0, e_busy = 1'b0;
  logic [VW-1:0] e_od_r = '0, e_od_n = '0;
  int            out_cnt = 0;
  int            done_cnt = 0;
  bit            lit_mode = 1'b0;
  bit            exp_ar, consume, nd;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_out_valid", VW'(out_valid), VW'(0));
      check("rst_out_data", out_data, '0);
      check("rst_acc_ready", VW'(acc_ready), VW'(0));
      check("rst_busy", VW'(busy), VW'(0));
      check("rst_done", VW'(done), VW'(0));
      check("rst_bias_sel", VW'(bias_sel), VW'(0));
      check("rst_out_data_n", out_data_n, '0);
      m_st = 0; m_g = 0; m_xfer = 1'b0; e_ov = 1'b0; e_done = 1'b0; e_busy = 1'b0;
      out_cnt = 0;
    end else begin
      exp_ar = (m_st == 1) && (!e_ov || out_ready);
      check("acc_ready", VW'(acc_ready), VW'(exp_ar));
      check("acc_ready_n", VW'(acc_ready_n), VW'(exp_ar));
      check("bias_sel", VW'(bias_sel), VW'(m_g));
      check("bias_sel_n", VW'(bias_sel_n), VW'(m_g));
      check("busy", VW'(busy), VW'(e_busy));
      check("busy_n", VW'(busy_n), VW'(e_busy));
      check("done", VW'(done), VW'(e_done));
      check("done_n", VW'(done_n), VW'(e_done));
      check("out_valid", VW'(out_valid), VW'(e_ov));
      check("out_valid_n", VW'(out_valid_n), VW'(e_ov));
      if (e_ov) begin
        check("out_data_relu", out_data, e_od_r);
        check("out_data_norelu", out_data_n, e_od_n);
      end
      if (e_done) begin
        check("outputs_per_tile", VW'(out_cnt), VW'(64));
        done_cnt++;
        out_cnt = 0;
      end

      consume = e_ov && out_ready;
      nd      = (m_st == 2) && (!e_ov || out_ready);
      m_xfer  = (m_st == 1) && acc_valid && exp_ar;
      if (consume) begin
        if (lit_mode) begin
          check("lit_lane0", VW'(lane_val(out_data, 0)), VW'(100 + out_cnt));
          check("lit_sat_pos", VW'(lane_val(out_data, 1)), VW'(131071));
          check("lit_relu_neg", VW'(lane_val(out_data, 2)), VW'(0));
          check("lit_sat_neg", VW'(lane_val(out_data_n, 2)), VW'(-131072));
        end
        out_cnt++;
      end
      if (m_xfer) begin
        e_od_r = model_out(acc_in, bias_mem[m_g], 1'b1);
        e_od_n = model_out(acc_in, bias_mem[m_g], 1'b0);
        e_ov   = 1'b1;
        if (m_g == G - 1) begin
          m_g  = 0;
          m_st = 2;
        end else begin
          m_g++;
        end
      end else if (consume) begin
        e_ov = 1'b0;
      end
      if (m_st == 0 && start) begin
        m_st = 1;
        m_g  = 0;
      end
      if (nd) m_st = 0;
      e_done = nd;
      e_busy = (m_st != 0);
    end
  end

  function automatic logic [VW-1:0] gen_word(input int mode);
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = rnd_lane();
    if (mode < 2) begin
      v[0*DW +: DW] = DW'(100);
      v[1*DW +: DW] = DW'(MAXV);
      v[2*DW +: DW] = DW'(MINV);
    end
    return v;
  endfunction

  // mode 0: back-to-back, 1: 5-cycle stall after first output,
  // 2: random handshakes, 3: random then reset at group 30.
  task automatic run_tile(input int mode);
    int  w, stall, dc0;
    bit  aborted;
    for (int g = 0; g < G; g++) begin
      for (int i = 0; i < N; i++) bias_mem[g][i*DW +: DW] = rnd_lane();
      if (mode < 2) begin
        bias_mem[g][0*DW +: DW] = DW'(g);
        bias_mem[g][1*DW +: DW] = DW'(10);
        bias_mem[g][2*DW +: DW] = DW'(-5);
      end
    end
    lit_mode = (mode < 2);
    acc_in   = gen_word(mode);
    if (mode >= 2) begin
      // acc_valid while idle must be ignored
      repeat (4) begin
        @(posedge clk); #1;
        acc_valid = 1'b1;
        out_ready = $urandom_range(0, 1) != 0;
      end
    end
    @(posedge clk); #1;
    start     = 1'b1;
    acc_valid = 1'b1;
    out_ready = 1'b1;
    dc0 = done_cnt; w = 0; stall = 0; aborted = 1'b0;
    for (int cyc = 0; cyc < 3000 && done_cnt == dc0 && !aborted; cyc++) begin
      @(posedge clk); #1;
      start = (mode >= 2) && (m_st != 0) && ($urandom_range(0, 7) == 0);
      if (m_xfer) begin
        w++;
        acc_in = gen_word(mode);
      end
      if (mode == 3 && w == 30) begin
        rst = 1'b1;
        acc_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        aborted = 1'b1;
      end else if (mode < 2) begin
        acc_valid = 1'b1;
        if (mode == 1 && w >= 1 && stall < 5) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        acc_valid = $urandom_range(0, 3) != 0;
        out_ready = $urandom_range(0, 3) != 0;
      end
    end
    start     = 1'b0;
    acc_valid = 1'b0;
    if (mode == 3) check("no_done_after_reset", VW'(done_cnt - dc0), VW'(0));
    else           check("tile_done_count", VW'(done_cnt - dc0), VW'(1));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; acc_valid = 1'b0; out_ready = 1'b0; acc_in = '0;
    for (int g = 0; g < G; g++) bias_mem[g] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    run_tile(0);
    run_tile(1);
    repeat (3) run_tile(2);
    run_tile(3);
    run_tile(2);
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
